// File: rtl/camera_register_file_if.sv
// -----------------------------------------------------------------------------
// camera_register_file_if
//   SPI-side transaction bus between the SPI peripheral and the camera
//   register file.
//
//   opcode        : current SPI opcode (8 bits)
//   operand       : write operand byte
//   operand_valid : one-cycle strobe, a write operand byte is present
//   operand_read  : one-cycle strobe, the response byte has been consumed
//   operand_count : index of the current byte within the transaction
//   response      : combinational read data returned to the SPI peripheral
//
//   master : the SPI peripheral (drives the request side)
//   slave  : the register file (drives response)
// -----------------------------------------------------------------------------
interface camera_register_file_if #(
  parameter int COUNT_WIDTH = 32
);
  logic [7:0]             opcode;
  logic [7:0]             operand;
  logic                   operand_valid;
  logic                   operand_read;
  logic [COUNT_WIDTH-1:0] operand_count;
  logic [7:0]             response;

  modport master (
    output opcode, operand, operand_valid, operand_read, operand_count,
    input  response
  );

  modport slave (
    input  opcode, operand, operand_valid, operand_read, operand_count,
    output response
  );
endinterface

// File: rtl/camera_register_file.sv
// -----------------------------------------------------------------------------
// camera_register_file
//   SPI-side register file for the camera pipeline. Decodes SPI opcodes into
//   camera control registers, runs the capture state machine from
//   START_CAPTURE through image drain, and returns image bytes, byte counts,
//   metering snapshots and a status byte on the SPI response path.
//   All state updates happen on the falling edge of clock_in.
//
// Ports
//   clock_in               : system clock (falling-edge active)
//   reset_in               : asynchronous active-high reset
//   spi                    : SPI transaction bus (slave side)
//   start_capture_out      : registered one-cycle capture pulse
//   compression_factor_out : JPEG quality select
//   power_save_enable_out  : D-PHY power save
//   gamma_bypass_out       : gamma bypass
//   zoom_out               : zoom factor
//   pan_out                : signed pan offset
//   image_ready_in         : high while the compressed image is valid
//   final_image_address_in : total image size minus 4
//   image_data_in          : buffer read data at image_address_out
//   image_address_out      : buffer read address
//   metering_in            : live metering values, channel k at [8k+7:8k]
//   capture_busy_out       : high while armed or capturing
// -----------------------------------------------------------------------------
module camera_register_file #(
  parameter  int ADDR_WIDTH        = 16,
  parameter  int METERING_CHANNELS = 6,
  parameter  int COUNT_WIDTH       = 32,
  localparam int NB                = (ADDR_WIDTH + 8) / 8
) (
  input  logic                           clock_in,
  input  logic                           reset_in,
  camera_register_file_if.slave          spi,
  output logic                           start_capture_out,
  output logic [1:0]                     compression_factor_out,
  output logic                           power_save_enable_out,
  output logic                           gamma_bypass_out,
  output logic [7:0]                     zoom_out,
  output logic [15:0]                    pan_out,
  input  logic                           image_ready_in,
  input  logic [ADDR_WIDTH-1:0]          final_image_address_in,
  input  logic [7:0]                     image_data_in,
  output logic [ADDR_WIDTH-1:0]          image_address_out,
  input  logic [8*METERING_CHANNELS-1:0] metering_in,
  output logic                           capture_busy_out
);

  localparam logic [7:0] OP_START_CAPTURE     = 8'd20;
  localparam logic [7:0] OP_BYTES_REMAINING   = 8'd21;
  localparam logic [7:0] OP_IMAGE_DATA        = 8'd22;
  localparam logic [7:0] OP_ZOOM              = 8'd23;
  localparam logic [7:0] OP_PAN               = 8'd24;
  localparam logic [7:0] OP_METERING          = 8'd25;
  localparam logic [7:0] OP_QUALITY_FACTOR    = 8'd26;
  localparam logic [7:0] OP_POWER_SAVE_ENABLE = 8'd28;
  localparam logic [7:0] OP_STATUS            = 8'd30;
  localparam logic [7:0] OP_COMPRESSED_BYTES  = 8'd31;
  localparam logic [7:0] OP_GAMMA_BYPASS      = 8'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURING,
    ST_READY,
    ST_DRAINED
  } state_e;

  state_e state, state_next;

  logic                           image_ready_flag;
  logic                           collision;
  logic [8*METERING_CHANNELS-1:0] snapshot;

  // Byte arithmetic is one bit wider than the address so that a full-size
  // image (final address at all-ones) still yields a correct total.
  logic [ADDR_WIDTH:0] total;
  logic [ADDR_WIDTH:0] addr_ext;
  logic [ADDR_WIDTH:0] remaining;
  logic                addr_below_total;
  logic                addr_can_advance;
  logic [NB*8-1:0]     remaining_ext;
  logic [NB*8-1:0]     final_ext;

  assign addr_ext         = {1'b0, image_address_out};
  assign total            = {1'b0, final_image_address_in} + (ADDR_WIDTH+1)'(4);
  assign addr_below_total = addr_ext < total;
  assign remaining        = addr_below_total ? (total - addr_ext) : '0;
  // The address register cannot represent total when total exceeds its
  // range, so it parks at all-ones instead of wrapping to zero.
  assign addr_can_advance = addr_below_total && !(&image_address_out);
  assign remaining_ext    = (NB*8)'(remaining);
  assign final_ext        = (NB*8)'(final_image_address_in);

  logic start_req;
  logic start_accept;
  logic collision_event;
  logic image_read;

  assign start_req       = spi.operand_valid && (spi.opcode == OP_START_CAPTURE);
  assign start_accept    = start_req && !capture_busy_out;
  assign collision_event = start_req && capture_busy_out;
  assign image_read      = spi.operand_read && (spi.opcode == OP_IMAGE_DATA);

  // ---------------------------------------------------------------------------
  // Capture FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(negedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned
    // (which would infer a latch).
    state_next = state;
    case (state)
      ST_IDLE:      if (start_accept) state_next = ST_ARMED;
      ST_ARMED:     state_next = ST_CAPTURING;
      ST_CAPTURING: if (image_ready_in) state_next = ST_READY;
      ST_READY: begin
        if (start_accept)           state_next = ST_ARMED;
        else if (!image_ready_in)   state_next = ST_IDLE;
        else if (!addr_can_advance) state_next = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (start_accept)         state_next = ST_ARMED;
        else if (!image_ready_in) state_next = ST_IDLE;
      end
      default:      state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture FSM: state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    capture_busy_out = 1'b0;
    image_ready_flag = 1'b0;
    case (state)
      ST_ARMED, ST_CAPTURING: capture_busy_out = 1'b1;
      ST_READY, ST_DRAINED:   image_ready_flag = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(negedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      start_capture_out      <= 1'b0;
      image_address_out      <= '0;
      snapshot               <= '0;
      collision              <= 1'b0;
      zoom_out               <= '0;
      pan_out                <= '0;
      compression_factor_out <= '0;
      power_save_enable_out  <= 1'b0;
      gamma_bypass_out       <= 1'b0;
    end else begin
      start_capture_out <= start_accept;

      // A new capture rewinds the buffer even if an image read lands on the
      // same edge.
      if (start_accept) begin
        image_address_out <= '0;
      end else if (image_read && (state == ST_READY) && addr_can_advance) begin
        image_address_out <= image_address_out + ADDR_WIDTH'(1);
      end

      if ((state == ST_CAPTURING) && image_ready_in) begin
        snapshot <= metering_in;
      end

      // Setting beats clearing so a collision during a status read is kept.
      if (collision_event) begin
        collision <= 1'b1;
      end else if (spi.operand_read && (spi.opcode == OP_STATUS)) begin
        collision <= 1'b0;
      end

      if (spi.operand_valid) begin
        case (spi.opcode)
          OP_ZOOM: begin
            if (spi.operand_count == '0) zoom_out <= spi.operand;
          end
          OP_PAN: begin
            if (spi.operand_count == COUNT_WIDTH'(0))      pan_out[15:8] <= spi.operand;
            else if (spi.operand_count == COUNT_WIDTH'(1)) pan_out[7:0]  <= spi.operand;
          end
          OP_QUALITY_FACTOR:    compression_factor_out <= spi.operand[1:0];
          OP_POWER_SAVE_ENABLE: power_save_enable_out  <= spi.operand[0];
          OP_GAMMA_BYPASS:      gamma_bypass_out       <= spi.operand[0];
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response mux
  // ---------------------------------------------------------------------------
  logic [7:0] response;

  always_comb begin
    response = 8'h00;
    case (spi.opcode)
      OP_BYTES_REMAINING: begin
        // Most significant byte first.
        for (int i = 0; i < NB; i++) begin
          if (spi.operand_count == COUNT_WIDTH'(i)) response = remaining_ext[8*(NB-1-i) +: 8];
        end
      end
      OP_IMAGE_DATA: response = addr_below_total ? image_data_in : 8'h00;
      OP_METERING: begin
        for (int i = 0; i < METERING_CHANNELS; i++) begin
          if (spi.operand_count == COUNT_WIDTH'(i)) response = snapshot[8*i +: 8];
        end
      end
      OP_STATUS: response = {5'b0, collision, capture_busy_out, image_ready_flag};
      OP_COMPRESSED_BYTES: begin
        // Least significant byte first.
        for (int i = 0; i < NB; i++) begin
          if (spi.operand_count == COUNT_WIDTH'(i)) response = final_ext[8*i +: 8];
        end
      end
      default: ;
    endcase
  end

  assign spi.response = response;

endmodule
